// File: rtl/vic_nest_ctrl.sv
// Nesting vectored interrupt controller: priority select, LIFO context stack, redirect/restore strobes.
// Optional tail-chaining on return is enabled by defining VIC_TAILCHAIN_EN.
module vic_nest_ctrl #(
  parameter int NUM_IRQ    = 8,
  parameter int NEST_DEPTH = 4,
  parameter int PC_W       = 32,
  parameter int CC_W       = 4,
  parameter int ISR_SHIFT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  i_irq_req,
  input  logic [NUM_IRQ-1:0]  i_irq_mask,
  input  logic [PC_W-1:0]     i_PC,
  input  logic [CC_W-1:0]     i_CCodes,
  input  logic                i_NOT_FLUSH,
  input  logic                i_reti,
  output logic                o_IRQ_PC,
  output logic [PC_W-1:0]     o_VIC_iaddr,
  output logic [CC_W-1:0]     o_VIC_CCodes,
  output logic                o_VIC_CCodes_ctrl,
  output logic                o_IRQ_VIC,
  output logic [NUM_IRQ-1:0]  o_irq_ack,
  output logic                o_stack_err
);
  localparam int CUR_W = $clog2(NUM_IRQ + 1);
  localparam int DEP_W = $clog2(NEST_DEPTH + 1);
  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [PC_W-1:0]    stk_pc_reg  [NEST_DEPTH];
  logic [CC_W-1:0]    stk_cc_reg  [NEST_DEPTH];
  logic [CUR_W-1:0]   stk_cur_reg [NEST_DEPTH];

  logic [CUR_W-1:0]   cur_reg;
  logic [DEP_W-1:0]   depth_reg, depth_next;
  logic               reti_d_reg, reti_pend_reg;
  logic               irq_pc_reg, cc_ctrl_reg, irq_vic_reg, stack_err_reg;
  logic [PC_W-1:0]    iaddr_reg;
  logic [CC_W-1:0]    cc_reg;
  logic [NUM_IRQ-1:0] ack_reg;

  logic [NUM_IRQ-1:0] pend, sel_onehot;
  logic [CUR_W-1:0]   sel, top_cur;
  logic [IDX_W-1:0]   top_idx, push_idx;
  logic               reti_evt, slot_free, ret_ok, take, pop, chain, err;

  assign pend = i_irq_req & i_irq_mask;

  always_comb begin
    sel = CUR_W'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) sel = CUR_W'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel == CUR_W'(gi));
    end
  endgenerate

  assign top_idx  = IDX_W'(depth_reg - DEP_W'(1));
  assign push_idx = IDX_W'(depth_reg);
  assign top_cur  = stk_cur_reg[top_idx];

  // A reti edge landing in the cycle right after a strobe is held over one cycle
  // so that redirects keep their two-cycle spacing without losing the return.
  assign reti_evt  = (i_reti & ~reti_d_reg) | reti_pend_reg;
  assign slot_free = ~irq_pc_reg;
  assign ret_ok    = slot_free & reti_evt & (depth_reg != '0);
  assign err       = slot_free & reti_evt & (depth_reg == '0);

`ifdef VIC_TAILCHAIN_EN
  assign chain = ret_ok & (pend != '0) & (sel < top_cur);
`else
  assign chain = 1'b0;
`endif

  assign pop  = ret_ok & ~chain;
  assign take = slot_free & ~reti_evt & (pend != '0) & (sel < cur_reg) &
                (depth_reg < DEP_W'(NEST_DEPTH)) & i_NOT_FLUSH;

  always_comb begin
    depth_next = depth_reg;
    if (take)
      depth_next = depth_reg + DEP_W'(1);
    else if (pop)
      depth_next = depth_reg - DEP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg       <= CUR_W'(NUM_IRQ);
      depth_reg     <= '0;
      reti_d_reg    <= 1'b0;
      reti_pend_reg <= 1'b0;
      irq_pc_reg    <= 1'b0;
      cc_ctrl_reg   <= 1'b0;
      irq_vic_reg   <= 1'b0;
      stack_err_reg <= 1'b0;
      iaddr_reg     <= '0;
      cc_reg        <= '0;
      ack_reg       <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_pc_reg[i]  <= '0;
        stk_cc_reg[i]  <= '0;
        stk_cur_reg[i] <= '0;
      end
    end else begin
      reti_d_reg    <= i_reti;
      reti_pend_reg <= reti_evt & irq_pc_reg;
      irq_pc_reg    <= take | pop | chain;
      cc_ctrl_reg   <= pop;
      ack_reg       <= (take | chain) ? sel_onehot : '0;
      depth_reg     <= depth_next;
      irq_vic_reg   <= (depth_next != '0);
      if (err)
        stack_err_reg <= 1'b1;
      if (take) begin
        stk_pc_reg[push_idx]  <= i_PC;
        stk_cc_reg[push_idx]  <= i_CCodes;
        stk_cur_reg[push_idx] <= cur_reg;
      end
      if (take | chain) begin
        cur_reg   <= sel;
        iaddr_reg <= PC_W'(sel) << ISR_SHIFT;
      end else if (pop) begin
        cur_reg   <= top_cur;
        iaddr_reg <= stk_pc_reg[top_idx];
        cc_reg    <= stk_cc_reg[top_idx];
      end
    end
  end

  assign o_IRQ_PC          = irq_pc_reg;
  assign o_VIC_iaddr       = iaddr_reg;
  assign o_VIC_CCodes      = cc_reg;
  assign o_VIC_CCodes_ctrl = cc_ctrl_reg;
  assign o_IRQ_VIC         = irq_vic_reg;
  assign o_irq_ack         = ack_reg;
  assign o_stack_err       = stack_err_reg;

endmodule

// File: tb/tb_vic_nest_ctrl.sv
// Scoreboard bench for vic_nest_ctrl: a queue/stack reference model predicts each redirect,
// a negedge monitor pops and compares whenever the DUT strobes. Honours VIC_TAILCHAIN_EN.
`timescale 1ns/1ps
module tb_vic_nest_ctrl;
  localparam int NUM_IRQ    = 8;
  localparam int NEST_DEPTH = 4;
  localparam int PC_W       = 32;
  localparam int CC_W       = 4;
  localparam int ISR_SHIFT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        req, mask;
  logic [31:0]       pc;
  logic [3:0]        cc;
  logic              nf, reti;
  logic              o_IRQ_PC, o_VIC_CCodes_ctrl, o_IRQ_VIC, o_stack_err;
  logic [31:0]       o_VIC_iaddr;
  logic [3:0]        o_VIC_CCodes;
  logic [7:0]        o_irq_ack;

  vic_nest_ctrl #(
    .NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST_DEPTH), .PC_W(PC_W), .CC_W(CC_W), .ISR_SHIFT(ISR_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_irq_req(req), .i_irq_mask(mask), .i_PC(pc), .i_CCodes(cc),
    .i_NOT_FLUSH(nf), .i_reti(reti),
    .o_IRQ_PC(o_IRQ_PC), .o_VIC_iaddr(o_VIC_iaddr), .o_VIC_CCodes(o_VIC_CCodes),
    .o_VIC_CCodes_ctrl(o_VIC_CCodes_ctrl), .o_IRQ_VIC(o_IRQ_VIC),
    .o_irq_ack(o_irq_ack), .o_stack_err(o_stack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] iaddr;
    logic [7:0]  ack;
    logic        ccctrl;
    logic [3:0]  cc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cc;
    int          cur;
  } frame_t;

  exp_t   exp_q[$];
  frame_t m_stack[$];
  int     m_cur = NUM_IRQ;
  bit     m_err = 1'b0;
  bit     m_strobe_out = 1'b0;
  logic   reti_prev = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endfunction

  // Reference model: predicts what the next rising edge does with the inputs now applied.
  task automatic model_step();
    exp_t       e;
    frame_t     f;
    int         sel = NUM_IRQ;
    logic [7:0] pend = req & mask;
    bit         edge_now = reti && !reti_prev;
    bit         blocked = m_strobe_out;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[i]) sel = i;
    reti_prev    = reti;
    m_strobe_out = 1'b0;
    e = '{cyc: cyc + 1, iaddr: 32'h0, ack: 8'h0, ccctrl: 1'b0, cc: 4'h0};
    if (edge_now && !blocked) begin
      if (m_stack.size() == 0) begin
        m_err = 1'b1;
      end else begin
`ifdef VIC_TAILCHAIN_EN
        if (sel < m_stack[$].cur) begin
          m_cur = sel;
          e.iaddr = 32'(sel) << ISR_SHIFT;
          e.ack = 8'(1) << sel;
          m_strobe_out = 1'b1;
        end else
`endif
        begin
          f = m_stack.pop_back();
          m_cur = f.cur;
          e.iaddr = f.pc;
          e.cc = f.cc;
          e.ccctrl = 1'b1;
          m_strobe_out = 1'b1;
        end
      end
    end else if (!edge_now && !blocked && sel < m_cur && m_stack.size() < NEST_DEPTH && nf) begin
      m_stack.push_back('{pc: pc, cc: cc, cur: m_cur});
      m_cur = sel;
      e.iaddr = 32'(sel) << ISR_SHIFT;
      e.ack = 8'(1) << sel;
      m_strobe_out = 1'b1;
    end
    if (m_strobe_out) exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_stack.delete();
    exp_q.delete();
    m_cur = NUM_IRQ;
    m_err = 1'b0;
    m_strobe_out = 1'b0;
    reti_prev = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reti();
    for (int k = 0; k < 20 && m_strobe_out; k++) step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    step();
  endtask

  exp_t mon_e;
  bit   due;

  // Monitor: one line per redirect transaction, compares against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_irq_pc", 64'(o_IRQ_PC), 64'(0));
      check("rst_iaddr", 64'(o_VIC_iaddr), 64'(0));
      check("rst_cc", 64'(o_VIC_CCodes), 64'(0));
      check("rst_cc_ctrl", 64'(o_VIC_CCodes_ctrl), 64'(0));
      check("rst_irq_vic", 64'(o_IRQ_VIC), 64'(0));
      check("rst_ack", 64'(o_irq_ack), 64'(0));
      check("rst_err", 64'(o_stack_err), 64'(0));
    end else begin
      due = (exp_q.size() != 0) && (exp_q[0].cyc <= cyc);
      check("strobe_present", 64'(o_IRQ_PC), 64'(due));
      if (due) begin
        mon_e = exp_q.pop_front();
        if (o_IRQ_PC) begin
          $display("cycle %0d: redirect iaddr=0x%0h ack=0x%0h cc_ctrl=%0b cc=0x%0h vic=%0b",
                   cyc, o_VIC_iaddr, o_irq_ack, o_VIC_CCodes_ctrl, o_VIC_CCodes, o_IRQ_VIC);
          check("iaddr", 64'(o_VIC_iaddr), 64'(mon_e.iaddr));
          check("ack", 64'(o_irq_ack), 64'(mon_e.ack));
          check("cc_ctrl", 64'(o_VIC_CCodes_ctrl), 64'(mon_e.ccctrl));
          if (mon_e.ccctrl) check("cc_restore", 64'(o_VIC_CCodes), 64'(mon_e.cc));
        end
      end else begin
        check("idle_ack", 64'(o_irq_ack), 64'(0));
        check("idle_cc_ctrl", 64'(o_VIC_CCodes_ctrl), 64'(0));
      end
      check("irq_vic", 64'(o_IRQ_VIC), 64'(m_stack.size() != 0));
      check("stack_err", 64'(o_stack_err), 64'(m_err));
    end
  end

  initial begin
    rst = 1'b0; req = 8'h00; mask = 8'hFF; pc = 32'h0; cc = 4'h0; nf = 1'b1; reti = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;

    // Single IRQ on channel 3, then return.
    req = 8'h08; pc = 32'h100; cc = 4'hA; step();
    req = 8'h00; step(); step();
    do_reti();
    step();

    // Deferral while execute holds a bubble.
    nf = 1'b0; req = 8'h01; pc = 32'h200;
    repeat (3) step();
    nf = 1'b1; pc = 32'h204; step();
    req = 8'h00; step();
    do_reti();
    step();

    // Nesting: ch5, then ch2 preempts, ch6 waits until both return.
    req = 8'h20; pc = 32'h300; cc = 4'h3; step(); step();
    req = 8'h04; pc = 32'h304; cc = 4'h4; step(); step();
    req = 8'h40; pc = 32'h308; step(); step();
    do_reti();
    do_reti();
    repeat (3) step();
    req = 8'h00; step();
    do_reti();
    step();

    // Tail chain: ch4 active, ch2 masked until the reti-edge cycle.
    req = 8'h10; pc = 32'h100; cc = 4'h5; step(); step();
    req = 8'h04; mask = 8'hFB; pc = 32'h400; step(); step();
    for (int k = 0; k < 20 && m_strobe_out; k++) step();
    mask = 8'hFF; reti = 1'b1; step();
    reti = 1'b0; repeat (4) step();
    req = 8'h00; step();
    for (int k = 0; k < 3; k++) do_reti();

    // Full stack, then underflow.
    for (int k = 7; k >= 4; k--) begin
      req = 8'(1) << k; pc = 32'h500 + 32'(k * 4); cc = 4'(k); step(); step();
    end
    req = 8'h01; step(); step(); step();
    do_reti();
    step(); step();
    req = 8'h00; step();
    for (int k = 0; k < 5; k++) do_reti();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom) | 8'($urandom);
      pc = $urandom & 32'hFFFF_FFFC;
      cc = 4'($urandom);
      nf = ($urandom_range(0, 4) != 0);
      if (!m_strobe_out && $urandom_range(0, 3) == 0) reti = ~reti;
      step();
    end
    req = 8'h00; reti = 1'b0; step(); step();
    for (int k = 0; k < 6; k++) do_reti();

    // Reset in the middle of an entry at depth 2.
    mask = 8'hFF; nf = 1'b1;
    req = 8'h20; pc = 32'h600; step(); step();
    req = 8'h04; pc = 32'h604; step(); step();
    req = 8'h00; step();
    req = 8'h01; pc = 32'h608;
    model_step();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    req = 8'h00;
    rst = 1'b1;
    repeat (5) step();

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
